// File: rtl/csr_exec_unit.sv
`timescale 1ns/1ps
// csr_exec_unit
// Execute-stage sequencer for Zicsr (csrrw/s/c and immediate forms), ecall
// and mret. It sits directly upstream of the CSR register file and issues at
// most one CSR file action per cycle.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake (in_ready only in IDLE)
//   in_op, in_funct3      : 00 CSR op, 01 ecall, 10 mret, 11 reserved
//   in_csr_addr           : CSR address
//   in_rs1_idx/data       : rs1 index (zimm for immediate forms) and value
//   in_pc                 : PC of the instruction (mepc on ecall)
//   out_valid/out_ready   : result handshake, result held until accepted
//   out_rd_we/rd_data     : rd write enable and old CSR value
//   out_redirect/_pc      : PC redirect request and its target
//   csr_*_o               : CSR file address/wdata/type/mepc/mcause
//   csr_rdata_i           : combinational read data for csr_addr_o
//   csr_pc_i              : registered trap PC from the CSR file
//
// Optional build macro CSR_EXEC_ILLEGAL_TRAP_EN: funct3 000/100, op 11 and
// CSR addresses outside mstatus/mtvec/mepc/mcause raise an illegal
// instruction trap (ecall action with mcause=2) instead of completing as a
// no-op / passing the address through.
module csr_exec_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 32'd11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [2:0]            in_funct3,
    input  logic [11:0]           in_csr_addr,
    input  logic [4:0]            in_rs1_idx,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_rd_we,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    output logic                  out_redirect,
    output logic [DATA_WIDTH-1:0] out_redirect_pc,
    output logic [11:0]           csr_addr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic [2:0]            csr_type_o,
    output logic [DATA_WIDTH-1:0] csr_mepc_o,
    output logic [DATA_WIDTH-1:0] csr_mcause_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    input  logic [DATA_WIDTH-1:0] csr_pc_i
);

    localparam logic [2:0] TYPE_NONE  = 3'b000;
    localparam logic [2:0] TYPE_WRITE = 3'b001;
    localparam logic [2:0] TYPE_ECALL = 3'b011;
    localparam logic [2:0] TYPE_MRET  = 3'b101;
    localparam logic [DATA_WIDTH-1:0] ILLEGAL_CAUSE = DATA_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_TRAP, S_PCWAIT, S_DONE
    } state_t;

    state_t                state_q;
    logic                  in_ready_q, out_valid_q, rd_we_q, redirect_q;
    logic [DATA_WIDTH-1:0] rd_data_q, redirect_pc_q;
    logic [2:0]            type_q, funct3_q;
    logic [11:0]           addr_q;
    logic [4:0]            rs1_idx_q;
    logic [DATA_WIDTH-1:0] rs1_data_q, old_q, wdata_q, mepc_q, mcause_q;
    logic [DATA_WIDTH-1:0] operand, new_d;
    logic                  illegal_req;

`ifdef CSR_EXEC_ILLEGAL_TRAP_EN
    function automatic logic addr_supported(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
    endfunction

    assign illegal_req = (in_op == 2'b11) ||
                         ((in_op == 2'b00) && ((in_funct3[1:0] == 2'b00) ||
                                               !addr_supported(in_csr_addr)));
`else
    assign illegal_req = 1'b0;
`endif

    // Read-modify-write value, evaluated against the live read data in READ.
    always_comb begin
        operand = funct3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_data_q;
        case (funct3_q[1:0])
            2'b01:   new_d = operand;
            2'b10:   new_d = csr_rdata_i | operand;
            2'b11:   new_d = csr_rdata_i & ~operand;
            default: new_d = csr_rdata_i;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            rd_we_q       <= 1'b0;
            rd_data_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            type_q        <= TYPE_NONE;
            funct3_q      <= '0;
            addr_q        <= '0;
            rs1_idx_q     <= '0;
            rs1_data_q    <= '0;
            old_q         <= '0;
            wdata_q       <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
        end else begin
            // CSR actions last exactly one cycle: cleared unless re-armed below.
            type_q <= TYPE_NONE;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        funct3_q   <= in_funct3;
                        addr_q     <= in_csr_addr;
                        rs1_idx_q  <= in_rs1_idx;
                        rs1_data_q <= in_rs1_data;
                        if (illegal_req) begin
                            state_q  <= S_TRAP;
                            type_q   <= TYPE_ECALL;
                            mepc_q   <= in_pc;
                            mcause_q <= ILLEGAL_CAUSE;
                        end else begin
                            case (in_op)
                                2'b00: state_q <= S_READ;
                                2'b01: begin
                                    state_q  <= S_TRAP;
                                    type_q   <= TYPE_ECALL;
                                    mepc_q   <= in_pc;
                                    mcause_q <= ECALL_CAUSE;
                                end
                                2'b10: begin
                                    state_q <= S_TRAP;
                                    type_q  <= TYPE_MRET;
                                end
                                default: begin
                                    state_q     <= S_DONE;
                                    out_valid_q <= 1'b1;
                                    rd_we_q     <= 1'b0;
                                    redirect_q  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                S_READ: begin
                    old_q   <= csr_rdata_i;
                    wdata_q <= new_d;
                    if (funct3_q[1:0] == 2'b00) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        rd_we_q     <= 1'b0;
                    end else if ((funct3_q[1:0] != 2'b01) && (rs1_idx_q == 5'd0)) begin
                        // Set/clear with a zero mask is a pure read: no write issued.
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        rd_we_q     <= 1'b1;
                        rd_data_q   <= csr_rdata_i;
                    end else begin
                        state_q <= S_WRITE;
                        type_q  <= TYPE_WRITE;
                    end
                end
                S_WRITE: begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                    rd_we_q     <= 1'b1;
                    rd_data_q   <= old_q;
                end
                S_TRAP: begin
                    state_q <= S_PCWAIT;
                end
                S_PCWAIT: begin
                    // The CSR file's trap PC becomes valid the cycle after the action.
                    state_q       <= S_DONE;
                    out_valid_q   <= 1'b1;
                    rd_we_q       <= 1'b0;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_pc_i;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        rd_we_q     <= 1'b0;
                        redirect_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_rd_we       = rd_we_q;
    assign out_rd_data     = rd_data_q;
    assign out_redirect    = redirect_q;
    assign out_redirect_pc = redirect_pc_q;
    assign csr_addr_o      = addr_q;
    assign csr_wdata_o     = wdata_q;
    assign csr_type_o      = type_q;
    assign csr_mepc_o      = mepc_q;
    assign csr_mcause_o    = mcause_q;

endmodule
